// File: rtl/fifo_gen_pkg.sv
// Shared defaults and read-mode encodings for the fifo_gen block.
package fifo_gen_pkg;

  localparam int DEF_WORD_SIZE = 10;
  localparam int DEF_PTR       = 3;

  // Read mode selection for the FWFT parameter.
  localparam int FWFT_REGISTERED  = 0;
  localparam int FWFT_FALLTHROUGH = 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WORD_SIZE register array, one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
module fifo_mem
  import fifo_gen_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR-1:0]       wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [PTR-1:0]       rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  localparam int DEPTH = 1 << PTR;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_gen.sv
// Synchronous FIFO with occupancy count, programmable almost-full/empty flags,
// sticky overflow/underflow errors, and registered or fall-through read mode.
module fifo_gen
  import fifo_gen_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR,
  parameter int FWFT      = FWFT_REGISTERED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [PTR:0]         full_threshold,
  input  logic [PTR:0]         empty_threshold,
  input  logic                 error_clr,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic [PTR:0]         fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 error
);

  localparam int DEPTH = 1 << PTR;

  logic [PTR-1:0]       wr_ptr;
  logic [PTR-1:0]       rd_ptr;
  logic [WORD_SIZE-1:0] mem_rd;
  logic                 push;
  logic                 pop;

  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign pop  = fifo_rd && !fifo_empty;
  assign push = fifo_wr && (!fifo_full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A fresh error in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (fifo_wr && fifo_full && !pop) || (overflow && !error_clr);
      underflow <= (fifo_rd && fifo_empty) || (underflow && !error_clr);
    end
  end

  assign error        = overflow | underflow;
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == (PTR+1)'(DEPTH));
  assign almost_full  = (fifo_count >= full_threshold);
  assign almost_empty = (fifo_count <= empty_threshold);

  fifo_mem #(
    .WORD_SIZE (WORD_SIZE),
    .PTR       (PTR)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (fifo_data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  generate
    if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
      // Forced to zero while empty so reset shows a clean output.
      assign fifo_data_out = fifo_empty ? '0 : mem_rd;
    end else begin : g_reg
      logic [WORD_SIZE-1:0] dout_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)    dout_q <= '0;
        else if (pop) dout_q <= mem_rd;
      end
      assign fifo_data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_gen.sv
// Drives a registered-read and a fall-through instance with identical stimulus
// and scores both against a queue-based reference model.
module tb_fifo_gen;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_wr, fifo_rd, error_clr;
  logic [9:0] din;
  logic [3:0] fth, eth;

  logic [9:0] dout0, dout1;
  logic [3:0] cnt0, cnt1;
  logic full0, empty0, af0, ae0, ovf0, unf0, err0;
  logic full1, empty1, af1, ae1, ovf1, unf1, err1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [9:0] mq[$];
  logic [9:0] rd_exp[$];
  bit         m_ovf, m_unf;
  logic [9:0] last0;
  bit         m_pop, m_push, m_novf, m_nunf;

  fifo_gen #(.WORD_SIZE(10), .PTR(3), .FWFT(0)) dut_reg (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_data_in(din), .full_threshold(fth), .empty_threshold(eth),
    .error_clr(error_clr), .fifo_data_out(dout0), .fifo_count(cnt0),
    .fifo_full(full0), .fifo_empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .error(err0)
  );

  fifo_gen #(.WORD_SIZE(10), .PTR(3), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_data_in(din), .full_threshold(fth), .empty_threshold(eth),
    .error_clr(error_clr), .fifo_data_out(dout1), .fifo_count(cnt1),
    .fifo_full(full1), .fifo_empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .error(err1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the push/pop rules.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      rd_exp.delete();
      m_ovf = 0;
      m_unf = 0;
      last0 = '0;
    end else begin
      m_pop  = fifo_rd && (mq.size() != 0);
      m_push = fifo_wr && ((mq.size() != DEPTH) || m_pop);
      m_novf = fifo_wr && (mq.size() == DEPTH) && !m_pop;
      m_nunf = fifo_rd && (mq.size() == 0);
      if (m_pop) rd_exp.push_back(mq.pop_front());
      if (m_push) mq.push_back(din);
      m_ovf = m_novf || (m_ovf && !error_clr);
      m_unf = m_nunf || (m_unf && !error_clr);
    end
  end

  // Monitor: compare both instances against the model each cycle.
  initial forever begin
    int n;
    @(negedge clk);
    #1;
    n = mq.size();
    chk("count_reg",  cnt0, n);
    chk("count_fwft", cnt1, n);
    chk("full_reg",   full0,  n == DEPTH);
    chk("full_fwft",  full1,  n == DEPTH);
    chk("empty_reg",  empty0, n == 0);
    chk("empty_fwft", empty1, n == 0);
    chk("afull_reg",  af0, n >= int'(fth));
    chk("afull_fwft", af1, n >= int'(fth));
    chk("aempty_reg", ae0, n <= int'(eth));
    chk("aempty_fwft", ae1, n <= int'(eth));
    chk("ovf_reg",  ovf0, m_ovf);
    chk("ovf_fwft", ovf1, m_ovf);
    chk("unf_reg",  unf0, m_unf);
    chk("unf_fwft", unf1, m_unf);
    chk("err_reg",  err0, m_ovf | m_unf);
    chk("err_fwft", err1, m_ovf | m_unf);
    if (rd_exp.size() > 0) begin
      last0 = rd_exp.pop_front();
      chk("rd_data_reg", dout0, last0);
    end else begin
      chk("dout_hold_reg", dout0, last0);
    end
    if (n > 0) chk("head_fwft", dout1, mq[0]);
  end

  task automatic step(input bit wr, input bit rd, input logic [9:0] d, input bit clr = 1'b0);
    fifo_wr   = wr;
    fifo_rd   = rd;
    din       = d;
    error_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    fifo_wr = 0; fifo_rd = 0; error_clr = 0; din = '0;
    fth = 4'd6; eth = 4'd2;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_empty", empty0, 1);
    chk("reset_dout",  dout0, 0);

    // fill, overflow, clear, drain in order
    for (int i = 1; i <= 8; i++) step(1, 0, 10'(i));
    chk("full_after_8", full0, 1);
    step(1, 0, 10'h0AA);
    chk("ovf_9th", ovf0, 1);
    chk("count_9th", cnt0, 8);
    step(0, 0, 0, 1);
    chk("ovf_cleared", ovf0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0);
      chk("drain_order", dout0, i);
    end
    chk("empty_after_drain", empty0, 1);

    // simultaneous write+read while full
    for (int i = 0; i < 8; i++) step(1, 0, 10'($urandom_range(0, 1022)));
    step(1, 1, 10'h3FF);
    chk("count_full_rw", cnt0, 8);
    chk("no_ovf_full_rw", ovf0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("last_out_3ff", dout0, 10'h3FF);

    // underflow: output holds, then clear
    step(0, 1, 0);
    chk("unf_set", unf0, 1);
    chk("err_set", err0, 1);
    chk("unf_dout_hold", dout0, 10'h3FF);
    step(0, 0, 0, 1);
    chk("unf_clr", unf0, 0);
    chk("err_clr", err0, 0);

    // fall-through first word and wrap with push/pop
    step(1, 0, 10'h155);
    chk("fwft_first", dout1, 10'h155);
    chk("fwft_not_empty", empty1, 0);
    step(1, 0, 10'($urandom));
    step(1, 0, 10'($urandom));
    for (int i = 0; i < 20; i++) step(1, 1, 10'($urandom));
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // randomized traffic, biased to visit full then empty
    for (int i = 0; i < 400; i++) begin
      int wb;
      wb = (i < 200) ? 70 : 30;
      if (i % 25 == 0) begin
        fth = 4'($urandom_range(0, 8));
        eth = 4'($urandom_range(0, 8));
      end
      step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < (100 - wb),
           10'($urandom), $urandom_range(0, 15) == 0);
    end

    // asynchronous reset with five words stored
    fth = 4'd6; eth = 4'd2;
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 10'(i + 10'h20));
    step(0, 1, 0);
    step(1, 0, 10'h2A);
    chk("pre_reset_count", cnt0, 5);
    reset = 1'b1;
    #2;
    chk("async_cnt_reg",   cnt0, 0);
    chk("async_cnt_fwft",  cnt1, 0);
    chk("async_empty",     empty0, 1);
    chk("async_dout_reg",  dout0, 0);
    chk("async_dout_fwft", dout1, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 10'h077);
    step(0, 1, 0);
    chk("post_reset_rd", dout0, 10'h077);
    step(0, 0, 0);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
